// File: rtl/video_pattern_source.sv
// Avalon-ST synthetic video source: optional control packet, one RGB888 video
// packet per frame and an idle gap, with patterns and colours set over a slave port.
module video_pattern_source #(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CTRL_HDR  = 3'd1,
    CTRL_DATA = 3'd2,
    VID_HDR   = 3'd3,
    PIXELS    = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam logic [10:0] LAST_X   = 11'(IMAGE_W - 1);
  localparam logic [10:0] LAST_Y   = 11'(IMAGE_H - 1);
  localparam int          BAR_W    = (IMAGE_W / 8 < 1) ? 1 : IMAGE_W / 8;
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] W16      = 16'(IMAGE_W);
  localparam logic [15:0] H16      = 16'(IMAGE_H);
  // Control packet carries one nibble in the low half of each byte.
  localparam logic [23:0] CTRL_BEAT0 = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
  localparam logic [23:0] CTRL_BEAT1 = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
  localparam logic [23:0] CTRL_BEAT2 = {8'h00, 4'h0, H16[3:0], 4'h0, H16[7:4]};

  function automatic logic [23:0] ctrl_beat(input logic [1:0] idx);
    case (idx)
      2'd0:    ctrl_beat = CTRL_BEAT0;
      2'd1:    ctrl_beat = CTRL_BEAT1;
      2'd2:    ctrl_beat = CTRL_BEAT2;
      default: ctrl_beat = 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pixel_value(
    input logic [1:0]  pat,
    input logic [10:0] px,
    input logic [10:0] py,
    input logic [2:0]  bar,
    input logic [23:0] colour,
    input logic [10:0] bx0,
    input logic [10:0] by0,
    input logic [10:0] bx1,
    input logic [10:0] by1,
    input logic [7:0]  fc
  );
    case (pat)
      2'd0:    pixel_value = colour;
      2'd1:    pixel_value = bar_colour(bar);
      2'd2:    pixel_value = (px >= bx0 && px <= bx1 && py >= by0 && py <= by1) ? colour : 24'h000000;
      2'd3:    pixel_value = {px[7:0], py[7:0], fc};
      default: pixel_value = 24'h000000;
    endcase
  endfunction

  logic        enable_r, ctrl_pkt_en_r;
  logic [1:0]  pattern_r;
  logic [23:0] colour_r;
  logic [10:0] x0_r, y0_r, x1_r, y1_r;
  logic [31:0] frame_count_r;
  logic [31:0] readdata_r;

  logic        sh_ctrl_pkt_en_r;
  logic [1:0]  sh_pattern_r;
  logic [23:0] sh_colour_r;
  logic [10:0] sh_x0_r, sh_y0_r, sh_x1_r, sh_y1_r;

  state_t      state_r, state_s;
  logic [23:0] data_r, data_s;
  logic        valid_r, valid_s, sop_r, sop_s, eop_r, eop_s;
  logic [10:0] x_r, x_s, y_r, y_s, bar_cnt_r, bar_cnt_s;
  logic [2:0]  bar_idx_r, bar_idx_s;
  logic [1:0]  beat_cnt_r, beat_cnt_s;
  logic [15:0] gap_cnt_r, gap_cnt_s;
  logic        latch_s, frame_done_s, fire_s;
  logic [10:0] adv_x_s, adv_y_s, adv_bar_cnt_s;
  logic [2:0]  adv_bar_idx_s;
  logic        unused_s;

  assign unused_s     = ^s_writedata[31:27];
  assign fire_s       = valid_r & source_ready;
  assign source_data  = data_r;
  assign source_valid = valid_r;
  assign source_sop   = sop_r;
  assign source_eop   = eop_r;
  assign s_readdata   = readdata_r;

  // Register file writes and the completed-frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r      <= 1'b0;
      ctrl_pkt_en_r <= 1'b0;
      pattern_r     <= 2'd0;
      colour_r      <= 24'hFF0000;
      x0_r          <= 11'd100;
      y0_r          <= 11'd100;
      x1_r          <= 11'd199;
      y1_r          <= 11'd199;
      frame_count_r <= 32'd0;
    end else begin
      if (s_chipselect && s_write) begin
        case (s_address)
          3'd0: begin
            enable_r      <= s_writedata[0];
            ctrl_pkt_en_r <= s_writedata[1];
            pattern_r     <= s_writedata[3:2];
          end
          3'd1: colour_r <= s_writedata[23:0];
          3'd2: begin
            x0_r <= s_writedata[26:16];
            y0_r <= s_writedata[10:0];
          end
          3'd3: begin
            x1_r <= s_writedata[26:16];
            y1_r <= s_writedata[10:0];
          end
          default: ;
        endcase
      end
      if (s_chipselect && s_write && s_address == 3'd4) begin
        frame_count_r <= 32'd0;
      end else if (frame_done_s) begin
        frame_count_r <= frame_count_r + 32'd1;
      end
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= 32'd0;
    end else if (s_chipselect && s_read) begin
      case (s_address)
        3'd0:    readdata_r <= {28'd0, pattern_r, ctrl_pkt_en_r, enable_r};
        3'd1:    readdata_r <= {8'd0, colour_r};
        3'd2:    readdata_r <= {5'd0, x0_r, 5'd0, y0_r};
        3'd3:    readdata_r <= {5'd0, x1_r, 5'd0, y1_r};
        3'd4:    readdata_r <= frame_count_r;
        3'd5:    readdata_r <= 32'h1234EEE3;
        default: readdata_r <= 32'd0;
      endcase
    end
  end

  // Frame configuration is frozen when a frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_ctrl_pkt_en_r <= 1'b0;
      sh_pattern_r     <= 2'd0;
      sh_colour_r      <= 24'hFF0000;
      sh_x0_r          <= 11'd100;
      sh_y0_r          <= 11'd100;
      sh_x1_r          <= 11'd199;
      sh_y1_r          <= 11'd199;
    end else if (latch_s) begin
      sh_ctrl_pkt_en_r <= ctrl_pkt_en_r;
      sh_pattern_r     <= pattern_r;
      sh_colour_r      <= colour_r;
      sh_x0_r          <= x0_r;
      sh_y0_r          <= y0_r;
      sh_x1_r          <= x1_r;
      sh_y1_r          <= y1_r;
    end
  end

  // Raster position of the next pixel, with the bar index tracked by a counter.
  always_comb begin
    adv_x_s       = x_r + 11'd1;
    adv_y_s       = y_r;
    adv_bar_idx_s = bar_idx_r;
    adv_bar_cnt_s = bar_cnt_r + 11'd1;
    if (x_r == LAST_X) begin
      adv_x_s       = 11'd0;
      adv_y_s       = y_r + 11'd1;
      adv_bar_idx_s = 3'd0;
      adv_bar_cnt_s = 11'd0;
    end else if (bar_cnt_r == BAR_LAST) begin
      adv_bar_cnt_s = 11'd0;
      adv_bar_idx_s = (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
    end else begin
      adv_bar_cnt_s = bar_cnt_r + 11'd1;
      adv_bar_idx_s = bar_idx_r;
    end
  end

  // Next state and next output beat; outputs only move on a handshake or while idle.
  always_comb begin
    state_s      = state_r;
    data_s       = data_r;
    valid_s      = valid_r;
    sop_s        = sop_r;
    eop_s        = eop_r;
    x_s          = x_r;
    y_s          = y_r;
    bar_idx_s    = bar_idx_r;
    bar_cnt_s    = bar_cnt_r;
    beat_cnt_s   = beat_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    latch_s      = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_r) begin
          latch_s = 1'b1;
          valid_s = 1'b1;
          sop_s   = 1'b1;
          eop_s   = 1'b0;
          if (ctrl_pkt_en_r) begin
            state_s = CTRL_HDR;
            data_s  = 24'h00000F;
          end else begin
            state_s = VID_HDR;
            data_s  = 24'h000000;
          end
        end else begin
          valid_s = 1'b0;
          sop_s   = 1'b0;
          eop_s   = 1'b0;
        end
      end
      CTRL_HDR: begin
        if (fire_s) begin
          state_s    = CTRL_DATA;
          beat_cnt_s = 2'd0;
          data_s     = ctrl_beat(2'd0);
          sop_s      = 1'b0;
          eop_s      = 1'b0;
        end else begin
          state_s = CTRL_HDR;
        end
      end
      CTRL_DATA: begin
        if (fire_s && beat_cnt_r == 2'd2) begin
          state_s = VID_HDR;
          data_s  = 24'h000000;
          sop_s   = 1'b1;
          eop_s   = 1'b0;
        end else if (fire_s) begin
          beat_cnt_s = beat_cnt_r + 2'd1;
          data_s     = ctrl_beat(beat_cnt_r + 2'd1);
          eop_s      = (beat_cnt_r == 2'd1);
        end else begin
          state_s = CTRL_DATA;
        end
      end
      VID_HDR: begin
        if (fire_s) begin
          state_s   = PIXELS;
          x_s       = 11'd0;
          y_s       = 11'd0;
          bar_idx_s = 3'd0;
          bar_cnt_s = 11'd0;
          data_s    = pixel_value(sh_pattern_r, 11'd0, 11'd0, 3'd0, sh_colour_r,
                                  sh_x0_r, sh_y0_r, sh_x1_r, sh_y1_r, frame_count_r[7:0]);
          sop_s     = 1'b0;
          eop_s     = (LAST_X == 11'd0) && (LAST_Y == 11'd0);
        end else begin
          state_s = VID_HDR;
        end
      end
      PIXELS: begin
        if (fire_s && x_r == LAST_X && y_r == LAST_Y) begin
          state_s      = GAP;
          frame_done_s = 1'b1;
          gap_cnt_s    = 16'd0;
          valid_s      = 1'b0;
          eop_s        = 1'b0;
          data_s       = 24'h000000;
        end else if (fire_s) begin
          x_s       = adv_x_s;
          y_s       = adv_y_s;
          bar_idx_s = adv_bar_idx_s;
          bar_cnt_s = adv_bar_cnt_s;
          data_s    = pixel_value(sh_pattern_r, adv_x_s, adv_y_s, adv_bar_idx_s, sh_colour_r,
                                  sh_x0_r, sh_y0_r, sh_x1_r, sh_y1_r, frame_count_r[7:0]);
          eop_s     = (adv_x_s == LAST_X) && (adv_y_s == LAST_Y);
        end else begin
          state_s = PIXELS;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        sop_s   = 1'b0;
        eop_s   = 1'b0;
      end
    endcase
  end

  // FSM state, raster counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      data_r     <= 24'h000000;
      valid_r    <= 1'b0;
      sop_r      <= 1'b0;
      eop_r      <= 1'b0;
      x_r        <= 11'd0;
      y_r        <= 11'd0;
      bar_idx_r  <= 3'd0;
      bar_cnt_r  <= 11'd0;
      beat_cnt_r <= 2'd0;
      gap_cnt_r  <= 16'd0;
    end else begin
      state_r    <= state_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      sop_r      <= sop_s;
      eop_r      <= eop_s;
      x_r        <= x_s;
      y_r        <= y_s;
      bar_idx_r  <= bar_idx_s;
      bar_cnt_r  <= bar_cnt_s;
      beat_cnt_r <= beat_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source: a reference model queues expected
// beats per frame, a negedge monitor pops and compares every handshake.
module tb_video_pattern_source;

  localparam int W    = 32;
  localparam int H    = 8;
  localparam int GAP  = 4;
  localparam int NPIX = W * H;
  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [23:0] data;
  logic        valid, sop, eop;
  logic        ready = 1'b1;

  video_pattern_source #(.IMAGE_W(W), .IMAGE_H(H), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .s_chipselect(cs), .s_read(rd), .s_write(wr), .s_address(addr),
    .s_writedata(wdata), .s_readdata(rdata),
    .source_data(data), .source_valid(valid), .source_ready(ready),
    .source_sop(sop), .source_eop(eop)
  );

  initial forever #5 clk = ~clk;

  logic [25:0] exp_q [$];
  int checks = 0, passes = 0;
  int beats_seen = 0, cyc = 0, eop_cyc = 0, exp_fc = 0;
  bit rnd_ready = 1'b0, have_eop = 1'b0, prev_valid = 1'b0, stall_pending = 1'b0;
  logic [26:0] held = 27'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  function automatic int nib(input int v, input int k);
    return (v >> (4 * k)) & 15;
  endfunction

  function automatic logic [23:0] ref_pixel(input int pat, input int x, input int y,
      input logic [23:0] colour, input int x0, input int y0, input int x1, input int y1, input int fc);
    int idx;
    case (pat)
      0: return colour;
      1: begin
        idx = x / (W / 8);
        if (idx > 7) idx = 7;
        return BAR_TAB[idx];
      end
      2: return (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? colour : 24'h000000;
      default: return {8'(x), 8'(y), 8'(fc)};
    endcase
  endfunction

  task automatic push_frame(input bit ctrl, input int pat, input logic [23:0] colour,
      input int x0, input int y0, input int x1, input int y1, input int fc);
    if (ctrl) begin
      exp_q.push_back({1'b1, 1'b0, 24'h00000F});
      exp_q.push_back({2'b00, 24'((nib(W, 1) << 16) | (nib(W, 2) << 8) | nib(W, 3))});
      exp_q.push_back({2'b00, 24'((nib(H, 2) << 16) | (nib(H, 3) << 8) | nib(W, 0))});
      exp_q.push_back({2'b01, 24'((nib(H, 0) << 8) | nib(H, 1))});
    end
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({1'b0, (x == W - 1 && y == H - 1), ref_pixel(pat, x, y, colour, x0, y0, x1, y1, fc)});
  endtask

  // Monitor: every handshake is matched against the head of the queue.
  always @(negedge clk) begin
    logic [25:0] e;
    cyc++;
    if (reset) begin
      stall_pending = 1'b0;
      have_eop = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (stall_pending) check("stall_hold", 32'({valid, sop, eop, data}), 32'(held));
      if (valid && !prev_valid && have_eop) begin
        check("gap_at_least", 32'(cyc - eop_cyc - 1 >= GAP), 32'd1);
        have_eop = 1'b0;
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({sop, eop, data}), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({sop, eop, data}), 32'(e));
        end
        beats_seen++;
        if (eop) begin
          have_eop = 1'b1;
          eop_cyc = cyc;
        end
      end
      stall_pending = valid && !ready;
      held = {valid, sop, eop, data};
      prev_valid = valid;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    tick();
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    tick();
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] req);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, req);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_seen < target && n < 5000) begin tick(); n++; end
    if (beats_seen < target) check("wait_beats_timeout", 32'(beats_seen), 32'(target));
  endtask

  task automatic finish_frame();
    int n = 0, seen = 0;
    while (exp_q.size() != 0 && n < 5000) begin tick(); n++; end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (GAP + 10) begin tick(); if (valid) seen++; end
    check("quiet_after_frame", 32'(seen), 32'd0);
  endtask

  task automatic set_box(input int x0, input int y0, input int x1, input int y1);
    bus_write(3'd2, {5'd0, 11'(x0), 5'd0, 11'(y0)});
    bus_write(3'd3, {5'd0, 11'(x1), 5'd0, 11'(y1)});
  endtask

  // One frame: enable, then clear enable part-way through so exactly one frame runs.
  task automatic run_one_frame(input bit ctrl, input int pat, input logic [23:0] colour,
      input int x0, input int y0, input int x1, input int y1, input int stop_after);
    int start;
    bus_write(3'd1, {8'd0, colour});
    set_box(x0, y0, x1, y1);
    push_frame(ctrl, pat, colour, x0, y0, x1, y1, exp_fc);
    start = beats_seen;
    bus_write(3'd0, {28'd0, 2'(pat), ctrl, 1'b1});
    wait_beats(start + stop_after);
    bus_write(3'd0, {28'd0, 2'(pat), ctrl, 1'b0});
    finish_frame();
    exp_fc++;
  endtask

  task automatic check_reset_regs();
    read_check("rst_control", 3'd0, 32'h00000000);
    read_check("rst_colour", 3'd1, 32'h00FF0000);
    read_check("rst_box_tl", 3'd2, 32'h00640064);
    read_check("rst_box_br", 3'd3, 32'h00C700C7);
    read_check("rst_frame_count", 3'd4, 32'd0);
    read_check("id", 3'd5, 32'h1234EEE3);
    read_check("unmapped", 3'd6, 32'd0);
  endtask

  initial begin
    int start;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_outputs", 32'({valid, sop, eop, data}), 32'd0);
    check("rst_readdata", rdata, 32'd0);
    check_reset_regs();

    run_one_frame(1'b1, 0, 24'hFF0000, 100, 100, 199, 199, 1000 % NPIX);
    read_check("frame_count_1", 3'd4, 32'(exp_fc));
    run_one_frame(1'b0, 1, 24'h000000, 0, 0, 0, 0, 40);
    run_one_frame(1'b0, 2, 24'h00FF00, 5, 2, 12, 5, 10);
    run_one_frame(1'b1, 2, 24'h00FF00, 30, 0, 40, 7, 10);
    run_one_frame(1'b0, 3, 24'h000000, 0, 0, 0, 0, 10);
    rnd_ready = 1'b1;
    run_one_frame(1'b1, 3, 24'h000000, 0, 0, 0, 0, 20);
    run_one_frame(1'b0, 1, 24'h000000, 0, 0, 0, 0, 20);
    rnd_ready = 1'b0;
    read_check("frame_count_7", 3'd4, 32'(exp_fc));

    // Two back-to-back frames; a mid-frame COLOUR write only affects the second.
    bus_write(3'd1, 32'h00123456);
    push_frame(1'b1, 0, 24'h123456, 0, 0, 0, 0, exp_fc);
    push_frame(1'b1, 0, 24'hABCDEF, 0, 0, 0, 0, exp_fc + 1);
    start = beats_seen;
    bus_write(3'd0, 32'h00000003);
    wait_beats(start + 50);
    bus_write(3'd1, 32'h00ABCDEF);
    wait_beats(start + 5 + NPIX + 20);
    bus_write(3'd0, 32'h00000002);
    finish_frame();
    exp_fc += 2;
    read_check("frame_count_9", 3'd4, 32'(exp_fc));
    read_check("colour_rw", 3'd1, 32'h00ABCDEF);

    bus_write(3'd4, 32'hDEADBEEF);
    exp_fc = 0;
    read_check("frame_count_cleared", 3'd4, 32'd0);

    // Reset in the middle of a frame abandons the packet.
    push_frame(1'b0, 0, 24'h0F0F0F, 0, 0, 0, 0, exp_fc);
    bus_write(3'd1, 32'h000F0F0F);
    start = beats_seen;
    bus_write(3'd0, 32'h00000001);
    wait_beats(start + 100);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("reset_mid_outputs", 32'({valid, sop, eop, data}), 32'd0);
    check("reset_mid_readdata", rdata, 32'd0);
    exp_fc = 0;
    check_reset_regs();
    finish_frame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
